// File: rtl/eth_sniffer_pkg.sv
// Shared widths and types for the Ethernet sniffer port-filter stage.
package eth_sniffer_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned PORT_W  = 16;
    localparam int unsigned WIN_W   = 2 * DATA_W;
    localparam int unsigned NUM_OFF = (WIN_W - PORT_W) / 8 + 1;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [PORT_W-1:0] port_t;
    typedef logic [WIN_W-1:0]  window_t;

endpackage

// File: rtl/eth_port_comparator_if.sv
// Stream and control bundle between a stimulus source and the port comparator.
interface eth_port_comparator_if;
    import eth_sniffer_pkg::*;

    logic  clear;
    port_t flagged_port;
    word_t data_in;
    word_t data_out;
    logic  match;

    modport master (
        output clear,
        output flagged_port,
        output data_in,
        input  data_out,
        input  match
    );

    modport slave (
        input  clear,
        input  flagged_port,
        input  data_in,
        output data_out,
        output match
    );

endinterface

// File: rtl/port_window_match.sv
// Combinational search for a port value at every byte offset of a two-word window.
module port_window_match
    import eth_sniffer_pkg::*;
(
    input  window_t window,
    input  port_t   flagged_port,
    output logic    hit
);

    logic [NUM_OFF-1:0] offset_hit;

    // One comparator per byte alignment, including those straddling the word boundary.
    for (genvar k = 0; k < NUM_OFF; k++) begin : g_off
        assign offset_hit[k] = (window[8*k +: PORT_W] == flagged_port);
    end

    assign hit = |offset_hit;

endmodule

// File: rtl/eth_port_comparator.sv
// Three-stage stream pass-through with a sticky flag for a flagged port at any alignment.
module eth_port_comparator
    import eth_sniffer_pkg::*;
(
    input logic                  clk,
    input logic                  rst,
    eth_port_comparator_if.slave bus
);

    word_t s1;
    word_t s2;
    word_t data_out;
    logic  match;
    logic  hit;

    // Newer word is more significant, so a port split across words reads in order.
    port_window_match u_match (
        .window       ({s1, s2}),
        .flagged_port (bus.flagged_port),
        .hit          (hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1       <= '0;
            s2       <= '0;
            data_out <= '0;
            match    <= 1'b0;
        end else if (bus.clear) begin
            s1       <= '0;
            s2       <= '0;
            data_out <= '0;
            match    <= 1'b0;
        end else begin
            s1       <= bus.data_in;
            s2       <= s1;
            data_out <= s2;
            match    <= match | hit;
        end
    end

    assign bus.data_out = data_out;
    assign bus.match    = match;

endmodule

// File: tb/tb_eth_port_comparator.sv
// Directed bench for eth_port_comparator: alignment, straddle, extremes, clear and reset.
module tb_eth_port_comparator;
    import eth_sniffer_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    eth_port_comparator_if bus ();

    eth_port_comparator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_clear();
        bus.clear   = 1'b1;
        bus.data_in = 32'h0;
        step();
        bus.clear   = 1'b0;
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        rst              = 1'b1;
        bus.clear        = 1'b0;
        bus.flagged_port = 16'hABCD;
        bus.data_in      = 32'h0;

        // Reset
        step();
        chk("rst_data", bus.data_out, 32'h0);
        chk("rst_match", 32'(bus.match), 32'h0);
        rst = 1'b0;
        do_clear();
        chk("clr_data", bus.data_out, 32'h0);
        chk("clr_match", 32'(bus.match), 32'h0);

        // Aligned mid-word
        bus.data_in = 32'h00ABCD00;
        step();
        chk("mid_e1_match", 32'(bus.match), 32'h0);
        bus.data_in = 32'h0;
        step();
        step();
        chk("mid_e3_data", bus.data_out, 32'h00ABCD00);
        chk("mid_e3_match", 32'(bus.match), 32'h1);
        step();
        chk("mid_e4_data", bus.data_out, 32'h0);

        // Straddle across two words
        do_clear();
        bus.data_in = 32'hCD000000;
        step();
        chk("str_e1_match", 32'(bus.match), 32'h0);
        bus.data_in = 32'h000000AB;
        step();
        chk("str_e2_match", 32'(bus.match), 32'h0);
        bus.data_in = 32'h0;
        step();
        chk("str_e3_match", 32'(bus.match), 32'h1);
        chk("str_e3_data", bus.data_out, 32'hCD000000);
        step();
        chk("str_e4_data", bus.data_out, 32'h000000AB);
        step();
        chk("str_e5_data", bus.data_out, 32'h0);

        // Upper half
        do_clear();
        bus.data_in = 32'hABCD0000;
        step();
        bus.data_in = 32'h0;
        step();
        step();
        chk("up_data", bus.data_out, 32'hABCD0000);
        chk("up_match", 32'(bus.match), 32'h1);

        // Lower half in the newer word
        do_clear();
        bus.data_in = 32'h0;
        step();
        chk("lo_e1_match", 32'(bus.match), 32'h0);
        bus.data_in = 32'h0000ABCD;
        step();
        bus.data_in = 32'h0;
        step();
        chk("lo_e3_data", bus.data_out, 32'h0);
        chk("lo_e3_match", 32'(bus.match), 32'h1);

        // All-ones extreme
        do_clear();
        bus.flagged_port = 16'hFFFF;
        bus.data_in      = 32'hFFFFFFFF;
        step();
        step();
        bus.data_in = 32'h0;
        step();
        chk("ff_e3_data", bus.data_out, 32'hFFFFFFFF);
        chk("ff_e3_match", 32'(bus.match), 32'h1);
        step();
        chk("ff_e4_data", bus.data_out, 32'hFFFFFFFF);

        // Zero port on zero data
        do_clear();
        chk("zero_clr_match", 32'(bus.match), 32'h0);
        bus.flagged_port = 16'h0000;
        step();
        chk("zero_match", 32'(bus.match), 32'h1);

        // Stickiness on non-matching data
        bus.flagged_port = 16'hABCD;
        bus.data_in      = 32'h12345678;
        step();
        step();
        step();
        step();
        chk("sticky_match", 32'(bus.match), 32'h1);
        chk("sticky_data", bus.data_out, 32'h12345678);

        // Clear discards in-flight and incoming words
        bus.clear   = 1'b1;
        bus.data_in = 32'h55555555;
        step();
        bus.clear   = 1'b0;
        chk("clr2_match", 32'(bus.match), 32'h0);
        chk("clr2_data", bus.data_out, 32'h0);
        bus.data_in = 32'h0;
        step();
        chk("clr2_next_data", bus.data_out, 32'h0);

        // Asynchronous reset mid-stream
        bus.data_in = 32'hABCD0000;
        step();
        step();
        step();
        chk("pre_rst_match", 32'(bus.match), 32'h1);
        chk("pre_rst_data", bus.data_out, 32'hABCD0000);
        rst = 1'b1;
        #2;
        chk("async_rst_data", bus.data_out, 32'h0);
        chk("async_rst_match", 32'(bus.match), 32'h0);
        rst = 1'b0;
        bus.data_in = 32'h0;
        step();
        step();
        step();
        chk("post_rst_data", bus.data_out, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
